echo_processor: RTL and testbench
=================================

ECHO_PROCESSOR -- requirements
Module: echo_processor

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits, two's complement.
REQ-002 Parameter DEPTH, default 4096: delay-line entries; SHALL be a power of two, >= 4.
REQ-003 Parameter SHIFT, default 2: feedback gain of 2^-SHIFT, range 0..WIDTH-1.
REQ-004 sample_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sample_valid  in  1  input_sample is valid this cycle.
REQ-007 sample_ready  out  1  block accepts samples; low during buffer clear.
REQ-008 input_sample  in  WIDTH  dry input sample, signed.
REQ-009 delay_len  in  $clog2(DEPTH)  echo delay in accepted samples.
REQ-010 bypass  in  1  1 = pass dry input to output.
REQ-011 output_sample  out  WIDTH  registered wet output, signed.
REQ-012 output_valid  out  1  output_sample updated this cycle.

Function
REQ-013 FSM states CLEAR and RUN only; reset enters CLEAR.
REQ-014 CLEAR: write zero to delay-line entries 0..DEPTH-1, one per cycle; sample_ready low; after the last entry go to RUN (DEPTH cycles in CLEAR).
REQ-015 RUN: sample_ready high; a sample is accepted when sample_valid and sample_ready are both high.
REQ-016 sample_valid while sample_ready is low SHALL be ignored: no output, no pointer move.
REQ-017 Accepted sample x at write pointer wp: tap = entry (wp - D) mod DEPTH, D = delay_len, D = 0 treated as 1.
REQ-018 y = x + (tap >>> SHIFT), arithmetic (sign-preserving) shift; sum computed at WIDTH+1 bits.
REQ-019 When bypass is low, y is written to entry wp and driven on output_sample; when high, x is written to entry wp and driven on output_sample.
REQ-020 Write pointer increments by one per accepted sample, wrapping DEPTH-1 -> 0.
REQ-021 Latency: output_sample/output_valid register one cycle after acceptance; output_valid is a single-cycle pulse per accepted sample.
REQ-022 output_sample holds its last value when output_valid is low.
REQ-023 Tap read and write of the same accepted sample SHALL not conflict (read-before-write semantics for D = DEPTH-1 wrap and all D).
REQ-024 delay_len and bypass are sampled at acceptance; a change takes effect on the next accepted sample.

Reset
REQ-025 While reset_n is low: output_sample = 0, output_valid = 0, sample_ready = 0, write pointer = 0, state = CLEAR.
REQ-026 Reset asserted mid-RUN or mid-CLEAR SHALL abort at once; on release a full CLEAR restarts from entry 0.

Configuration
REQ-027 Macro ECHO_SATURATE_EN defined: y SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before write and output.
REQ-028 Macro ECHO_SATURATE_EN undefined: y SHALL wrap modulo 2^WIDTH (low WIDTH bits of the sum).

Structure
REQ-029 Package echo_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the saturate/wrap helper function.
REQ-030 Sub-module echo_delay_line SHALL implement the DEPTH x WIDTH circular buffer (one write port, one read port, read-before-write); echo_processor holds FSM, pointer and arithmetic.

Verification
REQ-031 Reset release, DEPTH=16 -> sample_ready low exactly 16 cycles, then high; output_valid never pulses meanwhile.
REQ-032 DEPTH=16, SHIFT=2, D=4, impulse 0x4000 then zeros -> outputs at accepted samples 0/4/8/12: 0x4000/0x1000/0x0400/0x0100, all others 0.
REQ-033 Negative impulse 0xC000, SHIFT=2, D=4 -> sample 4 output 0xF000 (sign kept).
REQ-034 SHIFT=1, D=1, constant 0x7000 -> sample 1 output 0x7FFF with ECHO_SATURATE_EN, 0xA800 without.
REQ-035 bypass=1 for samples 0..3 with x=0x1000, then bypass=0, D=4, x=0 -> sample 4 output 0x0400.
REQ-036 reset_n pulsed low mid-stream -> outputs zero asynchronously, full CLEAR repeats, first post-reset echo taps read 0.

Source files
------------

// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : echo_pkg
//  Description : Shared types and arithmetic helper for the echo processor.
//                Compile-time option ECHO_SATURATE_EN selects clamping of the
//                wet sum instead of two's-complement wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
package echo_pkg;

    // Two-state control: buffer clear after reset, then normal processing
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } echo_state_t;

    // Widest sample the helper supports; callers cast to their own WIDTH
    localparam int ECHO_MAX_W = 64;

    // Reduce a sign-extended sum to the range of a WIDTH-bit signed sample.
    // The result is sign-extended to ECHO_MAX_W bits so the caller can
    // truncate it to WIDTH bits without losing the sign.
    function automatic logic signed [ECHO_MAX_W-1:0] limit_sum(
        input logic signed [ECHO_MAX_W:0] sum,
        input int                         width
    );
        logic signed [ECHO_MAX_W:0] one;
        logic signed [ECHO_MAX_W:0] hi;
        logic signed [ECHO_MAX_W:0] lo;
        one = (ECHO_MAX_W+1)'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
`ifdef ECHO_SATURATE_EN
        if (sum > hi) begin
            limit_sum = ECHO_MAX_W'(hi);
        end else if (sum < lo) begin
            limit_sum = ECHO_MAX_W'(lo);
        end else begin
            limit_sum = ECHO_MAX_W'(sum);
        end
`else
        // Keep only the low width bits, re-extending their sign bit
        limit_sum = ECHO_MAX_W'((sum <<< (ECHO_MAX_W + 1 - width))
                                >>> (ECHO_MAX_W + 1 - width));
        if (hi < lo) begin
            limit_sum = '0;
        end
`endif
    endfunction

endpackage : echo_pkg
`default_nettype wire

// File: rtl/echo_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : echo_delay_line
//  Description : DEPTH x WIDTH circular sample buffer. One synchronous write
//                port and one asynchronous read port; a read in the same
//                cycle as a write returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4096
) (
    input  logic                     sample_clock,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [WIDTH-1:0]         write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [WIDTH-1:0]         read_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage write; contents are zeroed by the owner's clear sweep, not reset
    always_ff @(posedge sample_clock) begin
        if (write_en) begin
            r_mem[write_addr] <= write_data;
        end
    end

    // Read sees pre-edge contents, giving read-before-write ordering
    assign read_data = r_mem[read_addr];

endmodule : echo_delay_line
`default_nettype wire

// File: rtl/echo_processor.sv
`default_nettype none
// ============================================================================
//  Module      : echo_processor
//  Description : Feedback echo: y = x + (delay_line[wp - D] >>> SHIFT), with
//                y (or x when bypassed) written back into the delay line.
//                After reset the whole delay line is swept to zero before
//                samples are accepted. Define ECHO_SATURATE_EN to clamp the
//                wet sum; otherwise it wraps modulo 2^WIDTH.
//                DEPTH must be a power of two and at least 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_processor
    import echo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4096,
    parameter int SHIFT = 2
) (
    input  logic                     sample_clock,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic signed [WIDTH-1:0]  input_sample,
    input  logic [$clog2(DEPTH)-1:0] delay_len,
    input  logic                     bypass,
    output logic signed [WIDTH-1:0]  output_sample,
    output logic                     output_valid
);

    localparam int c_addr_w = $clog2(DEPTH);

    echo_state_t              r_state;
    echo_state_t              w_next_state;
    logic [c_addr_w-1:0]      r_wptr;
    logic [c_addr_w-1:0]      w_delay_eff;
    logic [c_addr_w-1:0]      w_read_addr;
    logic                     w_clearing;
    logic                     w_accept;
    logic                     w_mem_we;
    logic [WIDTH-1:0]         w_tap_raw;
    logic signed [WIDTH-1:0]  w_tap;
    logic signed [WIDTH-1:0]  w_tap_scaled;
    logic signed [WIDTH:0]    w_sum;
    logic signed [WIDTH-1:0]  w_wet;
    logic signed [WIDTH-1:0]  w_mem_wdata;

    // State register; reset always restarts the clear sweep
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leave CLEAR once the sweep has written the last entry
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (r_wptr == c_addr_w'(DEPTH - 1)) w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = CLEAR;
        endcase
    end

    // Decode state into handshake and clear-sweep controls
    always_comb begin
        sample_ready = 1'b0;
        w_clearing   = 1'b0;
        case (r_state)
            CLEAR:   w_clearing   = 1'b1;
            RUN:     sample_ready = 1'b1;
            default: w_clearing   = 1'b1;
        endcase
    end

    assign w_accept = sample_valid && sample_ready;

    // A zero delay would read the entry being written; treat it as one
    assign w_delay_eff = (delay_len == '0) ? c_addr_w'(1) : delay_len;
    assign w_read_addr = r_wptr - w_delay_eff;

    assign w_tap        = w_tap_raw;
    assign w_tap_scaled = w_tap >>> SHIFT;
    assign w_sum        = (WIDTH+1)'(input_sample) + (WIDTH+1)'(w_tap_scaled);
    assign w_wet        = WIDTH'(limit_sum((ECHO_MAX_W+1)'(w_sum), WIDTH));

    // The clear sweep shares the write port and the write pointer
    assign w_mem_we    = w_clearing || w_accept;
    assign w_mem_wdata = w_clearing ? '0 : (bypass ? input_sample : w_wet);

    // Write pointer doubles as clear address; wraps to 0 as RUN begins
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
        end else if (w_mem_we) begin
            r_wptr <= r_wptr + c_addr_w'(1);
        end
    end

    // Registered output: one-cycle valid pulse, sample held between pulses
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            output_sample <= '0;
            output_valid  <= 1'b0;
        end else begin
            output_valid <= w_accept;
            if (w_accept) begin
                output_sample <= w_mem_wdata;
            end
        end
    end

    echo_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_delay_line (
        .sample_clock (sample_clock),
        .write_en     (w_mem_we),
        .write_addr   (r_wptr),
        .write_data   (w_mem_wdata),
        .read_addr    (w_read_addr),
        .read_data    (w_tap_raw)
    );

endmodule : echo_processor
`default_nettype wire

// File: tb/tb_echo_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_processor
//  Description : Self-checking bench for echo_processor (DEPTH=16). Two
//                instances share stimulus: dut_a with SHIFT=2, dut_b with
//                SHIFT=1. A behavioural echo model predicts both outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_processor;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        valid   = 1'b0;
    logic        byp     = 1'b0;
    logic [15:0] x       = '0;
    logic [3:0]  dl      = '0;
    logic        rdy_a, rdy_b, ov_a, ov_b;
    logic [15:0] out_a, out_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    int          wp;
    int          clear_left;
    bit          exp_v;
    logic [15:0] exp_a, exp_b;

    always #5 clk = ~clk;

    echo_processor #(.WIDTH(16), .DEPTH(16), .SHIFT(2)) dut_a (
        .sample_clock (clk),   .reset_n      (rst_n),
        .sample_valid (valid), .sample_ready (rdy_a),
        .input_sample (x),     .delay_len    (dl),
        .bypass       (byp),   .output_sample(out_a),
        .output_valid (ov_a)
    );

    echo_processor #(.WIDTH(16), .DEPTH(16), .SHIFT(1)) dut_b (
        .sample_clock (clk),   .reset_n      (rst_n),
        .sample_valid (valid), .sample_ready (rdy_b),
        .input_sample (x),     .delay_len    (dl),
        .bypass       (byp),   .output_sample(out_b),
        .output_valid (ov_b)
    );

    // y = x + tap * 2^-sh (floor), then clamp or wrap to 16 bits
    function automatic logic [15:0] wet(logic [15:0] xs, logic [15:0] tap, int sh);
        logic signed [15:0] xv, tv;
        int s;
        xv = xs;
        tv = tap;
        s  = int'(xv) + (int'(tv) >>> sh);
`ifdef ECHO_SATURATE_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    // Drive one cycle of inputs, advance the model across the rising edge
    task automatic step(bit v, logic [15:0] xs, logic [3:0] d, bit b);
        int dd, ra;
        logic [15:0] ya, yb;
        valid = v; x = xs; dl = d; byp = b;
        @(posedge clk);
        if (clear_left > 0) begin
            clear_left--;
            exp_v = 1'b0;
        end else if (v) begin
            dd = (d == 0) ? 1 : int'(d);
            ra = (wp - dd) & 15;
            ya = b ? xs : wet(xs, mem_a[ra], 2);
            yb = b ? xs : wet(xs, mem_b[ra], 1);
            mem_a[wp] = ya;
            mem_b[wp] = yb;
            exp_a = ya;
            exp_b = yb;
            exp_v = 1'b1;
            wp = (wp + 1) & 15;
        end else begin
            exp_v = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        clear_left = 16; wp = 0; exp_v = 1'b0; exp_a = '0; exp_b = '0;
        for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    endtask

    // Asynchronous reset pulse between edges, then run out the clear sweep
    task automatic apply_reset();
        #2 rst_n = 1'b0; valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        while (clear_left > 0) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        int n, pulses;
        #2 rst_n = 1'b0; valid = 1'b0;
        model_reset();
        #1;
        checks++; if (out_a !== 16'h0 || out_b !== 16'h0) begin errors++; $display("FAIL reset_out: got %h/%h want 0000", out_a, out_b); end
        checks++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b want 0", ov_a, ov_b); end
        checks++; if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b want 0", rdy_a, rdy_b); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0; pulses = 0;
        while (rdy_a !== 1'b1 && n < 40) begin
            step(1'b1, 16'($urandom), 4'd4, 1'b0);   // valid while not ready must be ignored
            n++;
            if (ov_a !== 1'b0 || ov_b !== 1'b0) pulses++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL clear_cycles: got %0d want 16", n); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clear_pulses: got %0d want 0", pulses); end
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL ready_after_clear_b: got %b want 1", rdy_b); end
    endtask

    task automatic test_impulse();
        logic [15:0] c;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 0) ? 16'h4000 : 16'h0000, 4'd4, 1'b0);
            c = (i % 4 == 0) ? (16'h4000 >> (2 * (i / 4))) : 16'h0000;
            checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL impulse_valid[%0d]: got %b want 1", i, ov_a); end
            checks++; if (out_a !== c) begin errors++; $display("FAIL impulse_a[%0d]: got %h want %h", i, out_a, c); end
            checks++; if (out_b !== exp_b) begin errors++; $display("FAIL impulse_b[%0d]: got %h want %h", i, out_b, exp_b); end
        end
    endtask

    task automatic test_negative();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 16'hC000 : 16'h0000, 4'd4, 1'b0);
            checks++; if (out_a !== exp_a) begin errors++; $display("FAIL negative_a[%0d]: got %h want %h", i, out_a, exp_a); end
            if (i == 4) begin
                checks++; if (out_a !== 16'hF000) begin errors++; $display("FAIL negative_sign: got %h want f000", out_a); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] c;
`ifdef ECHO_SATURATE_EN
        c = 16'h7FFF;
`else
        c = 16'hA800;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h7000, 4'd1, 1'b0);
            checks++; if (out_b !== exp_b) begin errors++; $display("FAIL sat_b[%0d]: got %h want %h", i, out_b, exp_b); end
            checks++; if (out_a !== exp_a) begin errors++; $display("FAIL sat_a[%0d]: got %h want %h", i, out_a, exp_a); end
            if (i == 1) begin
                checks++; if (out_b !== c) begin errors++; $display("FAIL sat_sample1: got %h want %h", out_b, c); end
            end
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h1000, 4'd4, 1'b1);
        checks++; if (out_a !== 16'h1000) begin errors++; $display("FAIL bypass_dry: got %h want 1000", out_a); end
        step(1'b1, 16'h0000, 4'd4, 1'b0);
        checks++; if (out_a !== 16'h0400) begin errors++; $display("FAIL bypass_echo: got %h want 0400", out_a); end
        checks++; if (out_b !== exp_b) begin errors++; $display("FAIL bypass_echo_b: got %h want %h", out_b, exp_b); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
            checks++; if (ov_a !== exp_v || ov_b !== exp_v) begin errors++; $display("FAIL random_valid[%0d]: got %b/%b want %b", i, ov_a, ov_b, exp_v); end
            checks++; if (out_a !== exp_a) begin errors++; $display("FAIL random_a[%0d]: got %h want %h", i, out_a, exp_a); end
            checks++; if (out_b !== exp_b) begin errors++; $display("FAIL random_b[%0d]: got %h want %h", i, out_b, exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] xs;
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 4'($urandom_range(1, 15)), 1'b0);
        #2 rst_n = 1'b0; valid = 1'b0;
        model_reset();
        #1;
        checks++; if (out_a !== 16'h0 || out_b !== 16'h0) begin errors++; $display("FAIL midreset_out: got %h/%h want 0000", out_a, out_b); end
        checks++; if (ov_a !== 1'b0 || rdy_a !== 1'b0) begin errors++; $display("FAIL midreset_ctl: got valid %b ready %b want 0 0", ov_a, rdy_a); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        while (rdy_a !== 1'b1 && n < 40) begin
            step(1'b1, 16'($urandom), 4'd8, 1'b0);
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL midreset_clear_cycles: got %0d want 16", n); end
        for (int i = 0; i < 10; i++) begin
            xs = 16'($urandom);
            step(1'b1, xs, 4'd8, 1'b0);
            if (i < 8) begin
                checks++; if (out_a !== xs || out_b !== xs) begin errors++; $display("FAIL midreset_tap0[%0d]: got %h/%h want %h", i, out_a, out_b, xs); end
            end
            checks++; if (out_a !== exp_a) begin errors++; $display("FAIL midreset_a[%0d]: got %h want %h", i, out_a, exp_a); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_impulse();
        test_negative();
        test_saturate();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule : tb_echo_processor
`default_nettype wire
